uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte-oriented UART transmitter peripheral that sits inside the local bus and drives the board-level txd pin. The firmware writes bytes through the bus. They are queued in a small FIFO and serialised as 8N1 frames at a rate set by a clock-cycle divider. The block also provides status bits for software polling and a one-cycle completion pulse for interrupt use.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DIV, CLK_HZ/BAUD, clock cycles per bit; must be >= 4
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries

Ports:
clk  in  1  system clock (the core/bus clock)
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  bus write strobe, one byte per asserted cycle
wr_data  in  8  byte to enqueue
full  out  1  FIFO full; writes while high are dropped
empty  out  1  FIFO empty
level  out  DEPTH_LOG2+1  current FIFO occupancy
busy  out  1  high while the shifter is in START, DATA, PAR or STOP
tx_done  out  1  one-cycle pulse at the end of each stop bit
overflow  out  1  sticky flag, set by any write attempted while full
ovf_clr  in  1  clears overflow
txd  out  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on the negedge of rst_n with no clock required.
- Reset values: txd=1, busy=0, tx_done=0, overflow=0, full=0, empty=1, level=0, FIFO pointers=0, FSM=IDLE, baud counter=0.
- Reset mid-frame: the frame is aborted, txd returns high immediately, and FIFO contents are discarded.
- FIFO:
  - Synchronous write. A write is accepted when wr_en=1 and full=0.
  - Pointers are DEPTH_LOG2+1 bits wide; the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
  - level = wptr - rptr, computed with the natural width.
  - Pop is internal only and occurs on the IDLE->START transition.
  - Simultaneous push and pop while full: the push is rejected, because full is evaluated before the pop. overflow is set.
  - Simultaneous push and pop while not full: level is unchanged.
  - Write to an empty FIFO: the data becomes visible to the FSM on the next cycle.
- overflow: set on wr_en & full. Cleared by ovf_clr. If both occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: txd=1. If empty=0, pop into an 8-bit shift register, clear the baud counter and go to START.
  - START: txd=0 for DIV cycles.
  - DATA: txd=shreg[0], LSB first. Shift right every DIV cycles. After 8 bits go to PAR if the parity option is compiled in, otherwise go to STOP.
  - STOP: txd=1 for DIV cycles. On the last cycle, pulse tx_done and return to IDLE.
- Baud counter:
  - Counts 0..DIV-1. A bit boundary occurs when the count equals DIV-1; the counter then wraps to 0.
  - Width is clog2(DIV).
- Frame timing:
  - Frame length is exactly 10*DIV cycles, or 11*DIV with parity.
  - Latency from an accepted write (FIFO empty, FSM idle) to the txd falling edge: 2 cycles (the write cycle, then the pop cycle).
- Back-to-back frames: if the FIFO is non-empty at tx_done, the next START begins on the cycle after tx_done, leaving 1 extra idle-high cycle between frames.
- busy deasserts in the same cycle the FSM enters IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PAR state is inserted after DATA. txd = XOR of the 8 data bits (even parity) for DIV cycles. Frame length is 11*DIV.
- Not defined: there is no PAR state and no parity logic; the frame is 8N1 with length 10*DIV.

Test Plan:
- Reset behaviour: with DIV=8, assert rst_n=0 mid-DATA.
  - Required: txd=1 and busy=0 asynchronously, before the next clk edge.
  - Required: level=0 after release.
- Single byte: DIV=8, write 0xA5 with the FIFO idle.
  - Required: txd falls 2 cycles after the write.
  - Required: line sequence is 0,1,0,1,0,0,1,0,1,1, each held 8 cycles.
  - Required: tx_done pulses at cycle 80 of the frame.
- Burst: write 0x01..0x05 on consecutive cycles.
  - Required: level peaks at 4, since one byte is popped immediately.
  - Required: 5 frames are sent in order, each 81 cycles start-to-start.
- Full and overflow: with DEPTH_LOG2=2, write 6 bytes in 6 cycles.
  - Required: full=1 and level=4; the 6th write is dropped and overflow=1.
  - Required: ovf_clr clears overflow; a simultaneous write-while-full with ovf_clr leaves overflow=1.
- Pointer wrap: push and pop 40 bytes through a 16-deep FIFO.
  - Required: bytes are received in order, and empty=1 with level=0 at the end.
- Parity: with UART_TX_PARITY_EN defined, send 0x07.
  - Required: parity bit = 1 and frame length = 88 cycles at DIV=8.
  - Required: with the macro undefined, frame length = 80 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART shifter, with polling status and a done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DIV        = CLK_HZ / BAUD,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
  localparam logic [DEPTH_LOG2:0]   PTR_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   PTR_ZERO = (DEPTH_LOG2 + 1)'(0);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                ovf_q, ovf_d;
  logic                push_s, pop_s, bnd_s;
  logic [7:0]          rd_data_s;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bit_q;
  logic [7:0]          shreg_q;
  logic                txd_q;
  logic                busy_q;
  logic                done_q;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif

  assign rd_data_s = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign bnd_s     = (cnt_q == CNT_LAST);

  // Full is taken from the registered flag, so a push in the same cycle as a pop while full is refused.
  always_comb begin
    push_s = wr_en & ~full_q;
    pop_s  = (state_q == S_IDLE) & ~empty_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    level_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[DEPTH_LOG2] != rptr_d[DEPTH_LOG2]) &&
              (wptr_d[DEPTH_LOG2-1:0] == rptr_d[DEPTH_LOG2-1:0]);
    if (wr_en & full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; contents become meaningless after reset because the pointers clear.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // FIFO pointers, status flags and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= PTR_ZERO;
      rptr_q  <= PTR_ZERO;
      level_q <= PTR_ZERO;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame shifter: txd, busy and tx_done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          cnt_q <= CNT_ZERO;
          if (pop_s) begin
            shreg_q <= rd_data_s;
            bit_q   <= 3'd0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^rd_data_s;
`endif
          end
        end
        S_START: begin
          if (bnd_s) begin
            cnt_q   <= CNT_ZERO;
            txd_q   <= shreg_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bnd_s) begin
            cnt_q <= CNT_ZERO;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= par_q;
              state_q <= S_PAR;
`else
              txd_q   <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              shreg_q <= {1'b0, shreg_q[7:1]};
              txd_q   <= shreg_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (bnd_s) begin
            cnt_q   <= CNT_ZERO;
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (bnd_s) begin
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= CNT_ZERO;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign overflow = ovf_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 16-deep instance carries the frame tests, a 4-deep one the full/overflow case.
module tb_uart_tx_fifo;

  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_wr_en, a_ovf_clr, b_wr_en, b_ovf_clr;
  logic [7:0] a_wr_data, b_wr_data;
  logic       a_full, a_empty, a_busy, a_tx_done, a_overflow, a_txd;
  logic       b_full, b_empty, b_busy, b_tx_done, b_overflow, b_txd;
  logic [4:0] a_level;
  logic [2:0] b_level;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fifo #(.DIV(DIV), .DEPTH_LOG2(4)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full(a_full), .empty(a_empty), .level(a_level), .busy(a_busy),
    .tx_done(a_tx_done), .overflow(a_overflow), .ovf_clr(a_ovf_clr), .txd(a_txd)
  );

  uart_tx_fifo #(.DIV(DIV), .DEPTH_LOG2(2)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .empty(b_empty), .level(b_level), .busy(b_busy),
    .tx_done(b_tx_done), .overflow(b_overflow), .ovf_clr(b_ovf_clr), .txd(b_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wdat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Called at frame cycle c0 (cycle 0 = first cycle txd is low); returns at the tx_done cycle.
  task automatic rx_frame(input logic [7:0] b, input int c0, output int bcnt);
    logic [10:0] fb;
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, ^b, b, 1'b0};
`else
    fb = {2'b11, b, 1'b0};
`endif
    bcnt = 0;
    for (int c = c0; c < FL * DIV; c++) begin
      chk("frame_txd", 32'(a_txd), 32'(fb[c / DIV]));
      if (c == FL * DIV - 1) chk("no_early_done", 32'(a_tx_done), 32'd0);
      if (a_busy) bcnt++;
      tick();
    end
    chk("tx_done_pulse", 32'(a_tx_done), 32'd1);
    chk("txd_idle_at_done", 32'(a_txd), 32'd1);
    chk("busy_low_at_done", 32'(a_busy), 32'd0);
  endtask

  initial begin
    int bc;
    int peak;
    int pushed;
    rst_n = 1'b0;
    a_wr_en = 1'b0; a_wr_data = 8'h00; a_ovf_clr = 1'b0;
    b_wr_en = 1'b0; b_wr_data = 8'h00; b_ovf_clr = 1'b0;
    tick();
    tick();
    chk("rst_txd", 32'(a_txd), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_tx_done), 32'd0);
    chk("rst_ovf", 32'(a_overflow), 32'd0);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_b_empty", 32'(b_empty), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_txd", 32'(a_txd), 32'd1);

    // Full / overflow on the 4-deep instance: 6 writes, first popped, 6th dropped.
    for (int i = 0; i < 6; i++) begin
      b_wr_en = 1'b1; b_wr_data = 8'(16 + i);
      tick();
    end
    b_wr_en = 1'b0;
    chk("b_full", 32'(b_full), 32'd1);
    chk("b_level4", 32'(b_level), 32'd4);
    chk("b_ovf_set", 32'(b_overflow), 32'd1);
    b_ovf_clr = 1'b1;
    tick();
    chk("b_ovf_cleared", 32'(b_overflow), 32'd0);
    b_wr_en = 1'b1; b_wr_data = 8'hEE;
    tick();
    b_wr_en = 1'b0; b_ovf_clr = 1'b0;
    chk("b_ovf_set_wins", 32'(b_overflow), 32'd1);
    chk("b_level_after_drop", 32'(b_level), 32'd4);
    b_ovf_clr = 1'b1;
    tick();
    b_ovf_clr = 1'b0;
    chk("b_ovf_cleared2", 32'(b_overflow), 32'd0);

    // Single byte 0xA5: txd falls two cycles after the write.
    a_wr_en = 1'b1; a_wr_data = 8'hA5;
    tick();
    a_wr_en = 1'b0;
    chk("single_level1", 32'(a_level), 32'd1);
    chk("single_txd_still_high", 32'(a_txd), 32'd1);
    tick();
    chk("single_busy", 32'(a_busy), 32'd1);
    chk("single_level0", 32'(a_level), 32'd0);
    rx_frame(8'hA5, 0, bc);
    chk("single_empty", 32'(a_empty), 32'd1);
    tick();
    chk("single_done_one_cycle", 32'(a_tx_done), 32'd0);
    tick();
    tick();

    // Burst 0x01..0x05: level peaks at 4, frames 81 cycles apart.
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      a_wr_en = 1'b1; a_wr_data = 8'(i + 1);
      tick();
      if (int'(a_level) > peak) peak = int'(a_level);
    end
    a_wr_en = 1'b0;
    chk("burst_peak", 32'(peak), 32'd4);
    rx_frame(8'h01, 3, bc);
    for (int i = 2; i <= 5; i++) begin
      tick();
      rx_frame(8'(i), 0, bc);
    end
    chk("burst_empty", 32'(a_empty), 32'd1);
    chk("burst_level0", 32'(a_level), 32'd0);
    tick();
    tick();

    // Pointer wrap: 40 bytes through the 16-deep FIFO, refilled on each tx_done cycle.
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_data = wdat(i);
      tick();
    end
    a_wr_en = 1'b0;
    pushed = 16;
    chk("wrap_level15", 32'(a_level), 32'd15);
    rx_frame(wdat(0), 14, bc);
    for (int k = 1; k < 40; k++) begin
      if (pushed < 40) begin
        a_wr_en = 1'b1; a_wr_data = wdat(pushed);
        pushed++;
      end
      tick();
      a_wr_en = 1'b0;
      rx_frame(wdat(k), 0, bc);
    end
    chk("wrap_empty", 32'(a_empty), 32'd1);
    chk("wrap_level0", 32'(a_level), 32'd0);
    chk("wrap_no_ovf", 32'(a_overflow), 32'd0);
    tick();
    tick();

    // Frame length with 0x07 (parity bit 1 when compiled in).
    a_wr_en = 1'b1; a_wr_data = 8'h07;
    tick();
    a_wr_en = 1'b0;
    tick();
    rx_frame(8'h07, 0, bc);
`ifdef UART_TX_PARITY_EN
    chk("frame_len_parity", 32'(bc), 32'd88);
`else
    chk("frame_len", 32'(bc), 32'd80);
`endif
    tick();
    tick();

    // Reset mid-DATA: txd high and FIFO cleared without a clock edge.
    a_wr_en = 1'b1; a_wr_data = 8'h00;
    tick();
    a_wr_data = 8'h5A;
    tick();
    tick();
    a_wr_en = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_data_txd_low", 32'(a_txd), 32'd0);
    chk("mid_data_busy", 32'(a_busy), 32'd1);
    chk("mid_data_level2", 32'(a_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 32'(a_txd), 32'd1);
    chk("async_rst_busy", 32'(a_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_level", 32'(a_level), 32'd0);
    chk("post_rst_empty", 32'(a_empty), 32'd1);
    chk("post_rst_txd", 32'(a_txd), 32'd1);
    chk("post_rst_busy", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
